// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register slave: FSM state encoding,
// fixed register indices and the default identification word.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int REG_ID      = 0;
  localparam int REG_WAITCFG = 1;
  localparam int REG_STATUS  = 2;
  localparam int REG_XFERCNT = 3;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA9B0_0001;

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between a master and the register slave (clock/reset travel separately).
// Completer drives PRDATA/PREADY/PSLVERROR; requester drives the rest.
interface apb_reg_slave_if;

  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERROR;

  modport master (
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    input  PRDATA, PREADY, PSLVERROR
  );

  modport slave (
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    output PRDATA, PREADY, PSLVERROR
  );

endinterface

// File: rtl/apb_reg_bank.sv
// Register storage, combinational read mux and write decode for the APB slave.
// Writes land on the clock edge where wr_en is high; reads are combinational on rd_idx.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE,
  localparam int         AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_dat,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_dat,
  input  logic          viol_set,
  input  logic          cnt_inc,
  output logic [3:0]    waitcfg
);

  // Entries 0..3 of scratch are never written; the read mux shadows them.
  logic [31:0] scratch [NUM_REGS];
  logic        status_viol;
  logic [31:0] xfercnt;
  logic        status_clr;

  assign status_clr = wr_en && (wr_idx == AW'(REG_STATUS)) && wr_dat[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitcfg     <= 4'd0;
      status_viol <= 1'b0;
      xfercnt     <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        scratch[i] <= 32'd0;
      end
    end else begin
      // A fresh violation wins over a coincident write-1-to-clear.
      status_viol <= viol_set | (status_viol & ~status_clr);
      if (cnt_inc) begin
        xfercnt <= xfercnt + 32'd1;
      end
      if (wr_en) begin
        if (wr_idx == AW'(REG_WAITCFG)) begin
          waitcfg <= wr_dat[3:0];
        end else if (wr_idx > AW'(REG_XFERCNT)) begin
          scratch[wr_idx] <= wr_dat;
        end
      end
    end
  end

  always_comb begin
    rd_dat = scratch[rd_idx];
    case (rd_idx)
      AW'(REG_ID):      rd_dat = ID_VALUE;
      AW'(REG_WAITCFG): rd_dat = {28'd0, waitcfg};
      AW'(REG_STATUS):  rd_dat = {31'd0, status_viol};
      AW'(REG_XFERCNT): rd_dat = xfercnt;
      default:          rd_dat = scratch[rd_idx];
    endcase
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer: FSM, programmable wait states and registered response around apb_reg_bank.
// PREADY rises WAITCFG access cycles after setup (same edge if 0); PREADY is the only backpressure.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_reg_slave_if.slave  apb
);

  localparam int AW = $clog2(NUM_REGS);

  state_t        state;
  logic [3:0]    cnt;
  logic [3:0]    waitcfg;
  logic [AW-1:0] lat_idx;
  logic          lat_wr;
  logic [31:0]   lat_wdat;
  logic          err_q;

  logic          ready_q;
  logic          slverr_q;
  logic [31:0]   prdata_q;

  logic [AW-1:0] live_idx;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_dat;
  logic          setup_seen;
  logic          access;
  logic          live_err;
  logic          complete;
  logic          commit_wr;
  logic          cnt_inc;
  logic          viol;

  assign setup_seen = apb.PSEL & ~apb.PENABLE;
  assign access     = apb.PSEL & apb.PENABLE;
  assign live_idx   = apb.PADDR[AW+1:2];

  assign live_err = (apb.PADDR[1:0] != 2'd0)
                  | (apb.PADDR[31:AW+2] != '0)
                  | (apb.PWRITE & ((live_idx == AW'(REG_ID)) | (live_idx == AW'(REG_XFERCNT))));

  // PREADY is high throughout RESP, so any access there is the completing edge.
  assign complete  = (state == ST_RESP) & access;
  assign commit_wr = complete & lat_wr & ~err_q;
  assign cnt_inc   = complete & ~err_q & ~(lat_wr & (lat_idx == AW'(REG_WAITCFG)));
  assign viol      = ((state == ST_IDLE) & apb.PENABLE) | ((state != ST_IDLE) & ~access);

  // Zero-wait reads must see the live address at the setup edge.
  assign rd_idx = (state == ST_IDLE) ? live_idx : lat_idx;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      lat_idx  <= '0;
      lat_wr   <= 1'b0;
      lat_wdat <= 32'd0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      prdata_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup_seen) begin
            lat_idx  <= live_idx;
            lat_wr   <= apb.PWRITE;
            lat_wdat <= apb.PWDATA;
            err_q    <= live_err;
            cnt      <= waitcfg;
            if (waitcfg == 4'd0) begin
              state    <= ST_RESP;
              ready_q  <= 1'b1;
              slverr_q <= live_err;
              prdata_q <= (!live_err && !apb.PWRITE) ? rd_dat : 32'd0;
            end else begin
              state <= ST_SETUP;
            end
          end
        end
        ST_SETUP, ST_WAIT: begin
          if (!access) begin
            state <= ST_IDLE;
          end else if (cnt == 4'd1) begin
            state    <= ST_RESP;
            ready_q  <= 1'b1;
            slverr_q <= err_q;
            prdata_q <= (!err_q && !lat_wr) ? rd_dat : 32'd0;
          end else begin
            cnt   <= cnt - 4'd1;
            state <= ST_WAIT;
          end
        end
        ST_RESP: begin
          // Either the transfer completes or the master abandoned it; both end here.
          state    <= ST_IDLE;
          ready_q  <= 1'b0;
          slverr_q <= 1'b0;
          prdata_q <= 32'd0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign apb.PREADY    = ready_q;
  assign apb.PSLVERROR = slverr_q;
  assign apb.PRDATA    = prdata_q;

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk      (PCLK),
    .rst      (PRESET),
    .rd_idx   (rd_idx),
    .rd_dat   (rd_dat),
    .wr_en    (commit_wr),
    .wr_idx   (lat_idx),
    .wr_dat   (lat_wdat),
    .viol_set (viol),
    .cnt_inc  (cnt_inc),
    .waitcfg  (waitcfg)
  );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: table of back-to-back APB transfers plus
// hand-written abort, violation, counter-wrap and mid-transfer reset sequences.
module tb_apb_reg_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_reg_slave_if bus();

  apb_reg_slave dut (
    .PCLK   (clk),
    .PRESET (rst),
    .apb    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic outs_zero(input string name);
    chk({name, "_pready"}, {31'd0, bus.PREADY}, 32'd0);
    chk({name, "_pslverr"}, {31'd0, bus.PSLVERROR}, 32'd0);
    chk({name, "_prdata"}, bus.PRDATA, 32'd0);
  endtask

  // Starts at posedge+1 with a setup phase; returns at posedge+1 after the completing edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                      output logic [31:0] rd, output logic err, output int waits);
    rd = 32'd0;
    err = 1'b0;
    waits = 0;
    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR = addr;
    bus.PWRITE = wr;
    bus.PWDATA = wdat;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    while (bus.PREADY !== 1'b1 && waits < 40) begin
      waits++;
      @(posedge clk); #1;
    end
    if (bus.PREADY !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout addr 0x%08h: PREADY low after %0d cycles, required high", addr, waits);
      bus.PSEL = 1'b0;
      bus.PENABLE = 1'b0;
      return;
    end
    rd = bus.PRDATA;
    err = bus.PSLVERROR;
    @(posedge clk); #1;
    chk("pready_drop", {31'd0, bus.PREADY}, 32'd0);
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp, input int exp_w);
    logic [31:0] rd;
    logic        err;
    int          w;
    xfer(1'b0, addr, 32'd0, rd, err, w);
    chk({name, "_rdata"}, rd, exp);
    chk({name, "_err"}, {31'd0, err}, 32'd0);
    chk({name, "_waits"}, 32'(w), 32'(exp_w));
  endtask

  task automatic wr_chk(input string name, input logic [31:0] addr, input logic [31:0] dat);
    logic [31:0] rd;
    logic        err;
    int          w;
    xfer(1'b1, addr, dat, rd, err, w);
    chk({name, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w;

    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PADDR = 32'd0;
    bus.PWRITE = 1'b0;
    bus.PWDATA = 32'd0;

    //            wr    addr    wdat           exp_rd         err   waits
    vecs[0]  = '{1'b1, 32'h04, 32'h0000_0003, 32'h0000_0000, 1'b0, 0};
    vecs[1]  = '{1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3};
    vecs[2]  = '{1'b0, 32'h0C, 32'h0,         32'h0000_0001, 1'b0, 3};
    vecs[3]  = '{1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
    vecs[4]  = '{1'b1, 32'h00, 32'h0000_1234, 32'h0000_0000, 1'b1, 3};
    vecs[5]  = '{1'b1, 32'h42, 32'h0000_0005, 32'h0000_0000, 1'b1, 3};
    vecs[6]  = '{1'b0, 32'h40, 32'h0,         32'h0000_0000, 1'b1, 3};
    vecs[7]  = '{1'b1, 32'h0C, 32'h0000_0007, 32'h0000_0000, 1'b1, 3};
    vecs[8]  = '{1'b0, 32'h0C, 32'h0,         32'h0000_0003, 1'b0, 3};
    vecs[9]  = '{1'b0, 32'h00, 32'h0,         32'hA9B0_0001, 1'b0, 3};
    vecs[10] = '{1'b1, 32'h04, 32'h0000_0000, 32'h0000_0000, 1'b0, 3};
    vecs[11] = '{1'b0, 32'h00, 32'h0,         32'hA9B0_0001, 1'b0, 0};
    vecs[12] = '{1'b0, 32'h04, 32'h0,         32'h0000_0000, 1'b0, 0};
    vecs[13] = '{1'b1, 32'h3C, 32'h55AA_55AA, 32'h0000_0000, 1'b0, 0};
    vecs[14] = '{1'b0, 32'h3C, 32'h0,         32'h55AA_55AA, 1'b0, 0};
    vecs[15] = '{1'b0, 32'h3D, 32'h0,         32'h0000_0000, 1'b1, 0};
    vecs[16] = '{1'b1, 32'h50, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 0};
    vecs[17] = '{1'b0, 32'h08, 32'h0,         32'h0000_0000, 1'b0, 0};
    vecs[18] = '{1'b0, 32'h0C, 32'h0,         32'h0000_000A, 1'b0, 0};
    vecs[19] = '{1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};

    repeat (3) @(posedge clk);
    #1;
    outs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    outs_zero("post_reset");

    // Table transfers run back-to-back with no idle cycle in between.
    for (int i = 0; i < 20; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdat, rd, err, w);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_waits", i), 32'(w), 32'(vecs[i].exp_waits));
    end

    // Master abandons a write during a two-cycle wait.
    wr_chk("wcfg2", 32'h04, 32'd2);
    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR = 32'h18;
    bus.PWRITE = 1'b1;
    bus.PWDATA = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    chk("abort_wait1", {31'd0, bus.PREADY}, 32'd0);
    @(posedge clk); #1;
    chk("abort_wait2", {31'd0, bus.PREADY}, 32'd0);
    bus.PENABLE = 1'b0;
    bus.PSEL = 1'b0;
    @(posedge clk); #1;
    chk("abort_after", {31'd0, bus.PREADY}, 32'd0);
    rd_chk("abort_nocommit", 32'h18, 32'd0, 2);
    rd_chk("abort_status", 32'h08, 32'd1, 2);
    wr_chk("abort_w1c", 32'h08, 32'd1);
    rd_chk("abort_cleared", 32'h08, 32'd0, 2);

    // PENABLE high while idle is a protocol violation.
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PENABLE = 1'b0;
    rd_chk("idle_pen_status", 32'h08, 32'd1, 2);
    wr_chk("idle_pen_w1c", 32'h08, 32'd1);
    rd_chk("idle_pen_cleared", 32'h08, 32'd0, 2);

    // Transfer counter wrap from all-ones.
    wr_chk("wcfg0", 32'h04, 32'd0);
    force dut.u_bank.xfercnt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.u_bank.xfercnt;
    rd_chk("wrap_id", 32'h00, 32'hA9B0_0001, 0);
    rd_chk("wrap_cnt", 32'h0C, 32'd0, 0);

    // Reset in the middle of a waited write.
    wr_chk("wcfg3", 32'h04, 32'd3);
    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR = 32'h14;
    bus.PWRITE = 1'b1;
    bus.PWDATA = 32'h1234_5678;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    outs_zero("midrst");
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge clk); #1;
    outs_zero("midrst_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("midrst_wcfg", 32'h04, 32'd0, 0);
    rd_chk("midrst_scr", 32'h14, 32'd0, 0);
    rd_chk("midrst_cnt", 32'h0C, 32'd2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit word registers (power of 2, 4..64).
REQ-002 SHALL have parameter ID_VALUE, default 32'hA9B0_0001, read-only content of register 0.
REQ-003 SHALL have port PCLK, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port PRESET, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port PADDR, input, 32 bits: byte address.
REQ-006 SHALL have ports PWRITE, PSEL and PENABLE, each input, 1 bit: APB control.
REQ-007 SHALL have port PWDATA, input, 32 bits: write data.
REQ-008 SHALL have port PRDATA, output, 32 bits, registered: read data.
REQ-009 SHALL have port PREADY, output, 1 bit, registered: transfer complete.
REQ-010 SHALL have port PSLVERROR, output, 1 bit, registered: transfer error, valid only while PREADY=1.

Function
REQ-011 SHALL implement an FSM with states IDLE, SETUP, WAIT and RESP.
- IDLE: wait for PSEL=1 with PENABLE=0.
- SETUP: request captured.
- WAIT: counting wait states.
- RESP: PREADY=1.
REQ-012 SHALL, on a PCLK edge with PSEL=1 and PENABLE=0, latch PADDR, PWRITE and PWDATA, load the wait counter from WAITCFG[3:0], and decode the address.
REQ-013 SHALL, if WAITCFG=0, assert PREADY at that same edge, giving a zero-wait access phase; otherwise it SHALL assert PREADY after WAITCFG access cycles of PREADY=0.
REQ-014 SHALL hold PRDATA, PREADY and PSLVERROR stable while PREADY=1, and deassert PREADY at the edge where PSEL&PENABLE&PREADY are sampled.
REQ-015 SHALL, on a read, drive PRDATA with the addressed register on the PREADY=1 cycle, and drive PRDATA=0 otherwise.
REQ-016 SHALL commit a write only at the completing edge (PSEL&PENABLE&PREADY), and only if PSLVERROR=0.
REQ-017 SHALL define the register map as follows (word index PADDR[log2(NUM_REGS)+1:2]):
- 0 ID: read-only.
- 1 WAITCFG[3:0]: read/write, upper bits read 0.
- 2 STATUS: bit0 = sticky protocol violation, write-1-to-clear.
- 3 XFERCNT: read-only count of completed non-error transfers, 32-bit, wraps 0xFFFF_FFFF -> 0.
- 4..NUM_REGS-1 SCRATCH: read/write.
REQ-018 SHALL assert PSLVERROR=1 with PREADY=1 for any of these:
- PADDR[1:0] != 0;
- PADDR >= 4*NUM_REGS;
- a write to register 0 or 3.
REQ-019 SHALL treat an error transfer as having no side effect: no register change, XFERCNT not incremented, PRDATA=0.
REQ-020 SHALL abort to IDLE and set STATUS[0] if PSEL or PENABLE drops while in WAIT or RESP; no commit SHALL occur.
REQ-021 SHALL set STATUS[0] if PENABLE=1 is seen in IDLE.
REQ-022 SHALL, when a W1C write to STATUS coincides with a new violation, leave STATUS[0]=1.
REQ-023 SHALL not increment XFERCNT for a write to WAITCFG that completes, but SHALL apply the new WAITCFG from the next setup phase onward.
REQ-024 SHALL accept back-to-back transfers, with a setup phase on the edge after completion, without an idle cycle.

Reset
REQ-025 SHALL, while PRESET=1 (asynchronous), hold the following values:
- FSM = IDLE;
- PREADY=0, PSLVERROR=0, PRDATA=0;
- WAITCFG, STATUS, XFERCNT and all SCRATCH = 0.
REQ-026 SHALL, on reset asserted mid-transfer, discard the transfer with no commit; the first edge after release SHALL be evaluated from IDLE.

Structure
REQ-027 SHALL place the state enum, the register index constants (REG_ID=0, REG_WAITCFG=1, REG_STATUS=2, REG_XFERCNT=3) and the default ID_VALUE in shared package apb_pkg.
REQ-028 SHALL implement register storage, read mux and write decode as one sub-module apb_reg_bank; the FSM, wait counter and response logic SHALL reside in apb_reg_slave.

Verification
REQ-029 Bench SHALL cover the following directed scenarios:
- Zero-wait read of 0x0 -> PREADY=1 in the first access cycle, PRDATA=0xA9B00001, PSLVERROR=0.
- Write 0x3 to 0x4, then write 0xDEADBEEF to 0x10 -> exactly 3 PREADY=0 access cycles, then PREADY=1; readback of 0x10 = 0xDEADBEEF; XFERCNT=1.
- Write to 0x0, write to 0x42, read 0x40 -> each PSLVERROR=1 with PREADY=1; no register changes; XFERCNT unchanged.
- PENABLE dropped during a WAITCFG=2 wait -> no commit; STATUS=1; a write of 1 to 0x8 clears it to 0.
- XFERCNT preloaded to 0xFFFFFFFF by force, then one good read -> XFERCNT=0.
- PRESET pulsed mid-wait on a write to 0x14 -> 0x14 reads 0; all outputs 0 during reset.
